// File: rtl/maverickOne_pkg.sv
// Core-wide sizing constants shared by the issue/launch logic.
package maverickOne_pkg;

    localparam int unsigned NUM_REGS        = 32;
    localparam int unsigned NUM_OUTSTANDING = 8;

endpackage

// File: rtl/reg_lock_tracker.sv
// reg_lock_tracker: per-register write-lock scoreboard plus in-flight counter.
// Locks are set on launch of a register-writing instruction and released on
// its writeback. All outputs come from registers unless REG_LOCK_WB_BYPASS_EN
// is defined, in which case a matching writeback frees locks_o/full_o in the
// same cycle (combinational wb_* -> locks_o/full_o path).
module reg_lock_tracker #(
    parameter int unsigned NR  = maverickOne_pkg::NUM_REGS,
    parameter int unsigned NOS = maverickOne_pkg::NUM_OUTSTANDING,
    localparam int unsigned RW = $clog2(NR),
    localparam int unsigned CW = $clog2(NOS + 1)
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    input  logic          clear_i,
    input  logic          launch_valid_i,
    input  logic [RW-1:0] launch_rd_i,
    input  logic          launch_wr_i,
    input  logic          wb_valid_i,
    input  logic [RW-1:0] wb_rd_i,
    input  logic          wb_wr_i,
    output logic [NR-1:0] locks_o,
    output logic [CW-1:0] outstanding_o,
    output logic          full_o,
    output logic          err_o
);

    logic [CW-1:0] cnt_q [NR];
    logic [CW-1:0] cnt_d [NR];
    logic [CW-1:0] tot_q, tot_d;
    logic [NR-1:0] locks_q, locks_d;
    logic          full_q, full_d;
    logic          err_q, err_d;

    logic launch_drop_c;
    logic wb_drop_c;
    logic launch_ok_c;
    logic wb_ok_c;

    // A launch while full is only legal when a writeback frees a slot this cycle.
    assign launch_drop_c = launch_valid_i && full_q && !wb_valid_i;
    // A writeback with nothing in flight has no instruction to retire.
    assign wb_drop_c     = wb_valid_i && (tot_q == '0);
    assign launch_ok_c   = launch_valid_i && !launch_drop_c;
    assign wb_ok_c       = wb_valid_i && !wb_drop_c;

    // Next-state for per-register counters, total counter, error and outputs.
    always_comb begin
        cnt_d   = cnt_q;
        tot_d   = tot_q;
        err_d   = err_q;
        locks_d = '0;
        full_d  = 1'b0;

        if (launch_drop_c || wb_drop_c) begin
            err_d = 1'b1;
        end

        unique case ({launch_ok_c, wb_ok_c})
            2'b10:   tot_d = tot_q + CW'(1);
            2'b01:   tot_d = tot_q - CW'(1);
            default: tot_d = tot_q;
        endcase

        for (int unsigned r = 1; r < NR; r++) begin
            logic inc;
            logic dec;
            inc = launch_ok_c && launch_wr_i && (launch_rd_i == RW'(r));
            dec = wb_ok_c && wb_wr_i && (wb_rd_i == RW'(r));
            if (inc && !dec) begin
                if (cnt_q[r] == CW'(NOS)) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + CW'(1);
                end
            end else if (dec && !inc) begin
                if (cnt_q[r] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CW'(1);
                end
            end
        end

        if (clear_i) begin
            for (int unsigned r = 0; r < NR; r++) begin
                cnt_d[r] = '0;
            end
            tot_d = '0;
            err_d = 1'b0;
        end

        for (int unsigned r = 1; r < NR; r++) begin
            locks_d[r] = (cnt_d[r] != '0);
        end
        full_d = (tot_d == CW'(NOS));
    end

    // State and registered outputs; reset drops every lock immediately.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int unsigned r = 0; r < NR; r++) begin
                cnt_q[r] <= '0;
            end
            tot_q   <= '0;
            locks_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tot_q   <= tot_d;
            locks_q <= locks_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign outstanding_o = tot_q;
    assign err_o         = err_q;

`ifdef REG_LOCK_WB_BYPASS_EN
    logic [NR-1:0] wb_free_c;

    // Registers whose last pending writer is writing back right now.
    always_comb begin
        wb_free_c = '0;
        for (int unsigned r = 1; r < NR; r++) begin
            wb_free_c[r] = wb_valid_i && wb_wr_i && (wb_rd_i == RW'(r))
                           && (cnt_q[r] == CW'(1));
        end
    end

    assign locks_o = locks_q & ~wb_free_c;
    assign full_o  = full_q && !wb_valid_i;
`else
    assign locks_o = locks_q;
    assign full_o  = full_q;
`endif

endmodule

// File: tb/tb_reg_lock_tracker.sv
// Directed bench for reg_lock_tracker (NR=32, NOS=8).
module tb_reg_lock_tracker;

    localparam int unsigned NR  = 32;
    localparam int unsigned NOS = 8;
    localparam int unsigned RW  = 5;
    localparam int unsigned CW  = 4;

`ifdef REG_LOCK_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          arst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          launch_valid_i = 1'b0;
    logic [RW-1:0] launch_rd_i = '0;
    logic          launch_wr_i = 1'b0;
    logic          wb_valid_i = 1'b0;
    logic [RW-1:0] wb_rd_i = '0;
    logic          wb_wr_i = 1'b0;
    logic [NR-1:0] locks_o;
    logic [CW-1:0] outstanding_o;
    logic          full_o;
    logic          err_o;

    int n_cmp = 0;
    int n_bad = 0;

    reg_lock_tracker #(.NR(NR), .NOS(NOS)) dut (
        .clk_i         (clk),
        .arst_ni       (arst_ni),
        .clear_i       (clear_i),
        .launch_valid_i(launch_valid_i),
        .launch_rd_i   (launch_rd_i),
        .launch_wr_i   (launch_wr_i),
        .wb_valid_i    (wb_valid_i),
        .wb_rd_i       (wb_rd_i),
        .wb_wr_i       (wb_wr_i),
        .locks_o       (locks_o),
        .outstanding_o (outstanding_o),
        .full_o        (full_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        clear_i        = 1'b0;
        launch_valid_i = 1'b0;
        launch_wr_i    = 1'b0;
        launch_rd_i    = '0;
        wb_valid_i     = 1'b0;
        wb_wr_i        = 1'b0;
        wb_rd_i        = '0;
    endtask

    task automatic launch(input int rd, input logic wr);
        launch_valid_i = 1'b1;
        launch_rd_i    = RW'(rd);
        launch_wr_i    = wr;
    endtask

    task automatic wback(input int rd, input logic wr);
        wb_valid_i = 1'b1;
        wb_rd_i    = RW'(rd);
        wb_wr_i    = wr;
    endtask

    task automatic do_clear();
        idle();
        clear_i = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        // Reset state
        idle();
        tick();
        tick();
        chk("rst_locks", 64'(locks_o), 64'h0);
        chk("rst_out", 64'(outstanding_o), 64'h0);
        chk("rst_full", 64'(full_o), 64'h0);
        chk("rst_err", 64'(err_o), 64'h0);
        arst_ni = 1'b1;
        tick();

        // Launch rd=5, then write it back
        launch(5, 1'b1);
        tick();
        idle();
        chk("l5_locks", 64'(locks_o), 64'h20);
        chk("l5_out", 64'(outstanding_o), 64'h1);
        wback(5, 1'b1);
        tick();
        idle();
        chk("wb5_locks", 64'(locks_o), 64'h0);
        chk("wb5_out", 64'(outstanding_o), 64'h0);
        chk("wb5_err", 64'(err_o), 64'h0);

        // rd=0 never locks but still counts as outstanding
        launch(0, 1'b1);
        tick();
        idle();
        chk("l0_locks", 64'(locks_o), 64'h0);
        chk("l0_out", 64'(outstanding_o), 64'h1);
        wback(0, 1'b1);
        tick();
        idle();
        chk("wb0_out", 64'(outstanding_o), 64'h0);
        chk("wb0_err", 64'(err_o), 64'h0);

        // Non-writing instruction: counted, no lock
        launch(6, 1'b0);
        tick();
        idle();
        chk("nw_locks", 64'(locks_o), 64'h0);
        chk("nw_out", 64'(outstanding_o), 64'h1);
        wback(6, 1'b0);
        tick();
        idle();
        chk("nw_wb_out", 64'(outstanding_o), 64'h0);
        chk("nw_wb_err", 64'(err_o), 64'h0);

        // Fill to NOS on rd=3
        for (int i = 0; i < int'(NOS); i++) begin
            launch(3, 1'b1);
            tick();
        end
        idle();
        chk("fill_full", 64'(full_o), 64'h1);
        chk("fill_out", 64'(outstanding_o), 64'(NOS));
        chk("fill_locks", 64'(locks_o), 64'h8);
        chk("fill_err", 64'(err_o), 64'h0);

        // Launch while full without writeback is dropped and flagged
        launch(3, 1'b1);
        tick();
        idle();
        chk("ovf_err", 64'(err_o), 64'h1);
        chk("ovf_out", 64'(outstanding_o), 64'(NOS));
        chk("ovf_full", 64'(full_o), 64'h1);

        // Launch + writeback of rd=3 together while full: counts unchanged
        launch(3, 1'b1);
        wback(3, 1'b1);
        #1;
        chk("lw_full_comb", 64'(full_o), 64'(!BYP));
        tick();
        idle();
        chk("lw_locks", 64'(locks_o), 64'h8);
        chk("lw_out", 64'(outstanding_o), 64'(NOS));
        chk("lw_full", 64'(full_o), 64'h1);

        // Drain: cnt[3] must be exactly NOS, so the lock survives NOS-1 releases
        for (int i = 0; i < int'(NOS) - 1; i++) begin
            wback(3, 1'b1);
            tick();
        end
        idle();
        chk("drain7_locks", 64'(locks_o), 64'h8);
        chk("drain7_out", 64'(outstanding_o), 64'h1);
        chk("drain7_full", 64'(full_o), 64'h0);
        wback(3, 1'b1);
        tick();
        idle();
        chk("drain8_locks", 64'(locks_o), 64'h0);
        chk("drain8_out", 64'(outstanding_o), 64'h0);
        chk("err_sticky", 64'(err_o), 64'h1);

        // Clear with a launch in the same cycle: launch ignored
        clear_i = 1'b1;
        launch(4, 1'b1);
        tick();
        idle();
        chk("clr_err", 64'(err_o), 64'h0);
        chk("clr_locks", 64'(locks_o), 64'h0);
        chk("clr_out", 64'(outstanding_o), 64'h0);

        // Release of an unlocked register
        launch(2, 1'b1);
        tick();
        idle();
        wback(7, 1'b1);
        tick();
        idle();
        chk("rel7_err", 64'(err_o), 64'h1);
        chk("rel7_locks", 64'(locks_o), 64'h4);
        tick();
        chk("rel7_sticky", 64'(err_o), 64'h1);
        do_clear();
        chk("clr2_err", 64'(err_o), 64'h0);
        chk("clr2_locks", 64'(locks_o), 64'h0);
        chk("clr2_out", 64'(outstanding_o), 64'h0);

        // Writeback with nothing outstanding: flagged, counter does not wrap
        wback(0, 1'b0);
        tick();
        idle();
        chk("uf_err", 64'(err_o), 64'h1);
        chk("uf_out", 64'(outstanding_o), 64'h0);
        do_clear();

        // Release latency for rd=9
        launch(9, 1'b1);
        tick();
        idle();
        chk("l9_locks", 64'(locks_o), 64'h200);
        wback(9, 1'b1);
        #1;
        chk("wb9_same_cycle", 64'(locks_o[9]), 64'(!BYP));
        tick();
        idle();
        chk("wb9_next_cycle", 64'(locks_o), 64'h0);
        chk("wb9_err", 64'(err_o), 64'h0);

        // Async reset mid-stream with three locks held
        launch(1, 1'b1);
        tick();
        launch(2, 1'b1);
        tick();
        launch(10, 1'b1);
        tick();
        idle();
        chk("pre_rst_locks", 64'(locks_o), 64'h406);
        chk("pre_rst_out", 64'(outstanding_o), 64'h3);
        #2;
        arst_ni = 1'b0;
        #1;
        chk("arst_locks", 64'(locks_o), 64'h0);
        chk("arst_out", 64'(outstanding_o), 64'h0);
        chk("arst_full", 64'(full_o), 64'h0);
        chk("arst_err", 64'(err_o), 64'h0);
        tick();
        arst_ni = 1'b1;
        tick();
        chk("post_rst_locks", 64'(locks_o), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
